// File: rtl/seq_approx_divider.sv
// Iterative restoring divider (2W / W) producing one quotient bit per clock,
// with an optional approximate-cell region selected by rows/columns at runtime.
module seq_approx_divider #(
  parameter int W           = 8,
  parameter int APPROX_ROWS = 4,
  parameter int APPROX_COLS = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] n,
  input  logic [W-1:0]   d,
  input  logic           approx_en,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   q,
  output logic [W-1:0]   r,
  output logic           dbz,
  output logic           ovf
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  logic [W:0]    p_q;
  logic [W-1:0]  d_q;
  logic [W-1:0]  nsh_q;
  logic [W-1:0]  qacc_q;
  logic [W-1:0]  rem_q;
  logic [IW-1:0] i_q;
  logic          apx_q;
  logic          dbz_pend_q;
  logic          ovf_pend_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [W-1:0]  q_q;
  logic [W-1:0]  r_q;
  logic          dbz_q;
  logic          ovf_q;

  logic          row_apx;
  logic [W:0]    bw;
  logic [W-1:0]  diff;
  logic          qbit;
  logic [W-1:0]  rem;

  assign row_apx = apx_q && (int'(i_q) < APPROX_ROWS);
  assign bw[0]   = 1'b0;

  // Trial subtraction P[W-1:0] - d as a borrow ripple; low columns may be approximate.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_col
      logic ex_diff;
      logic ex_bout;
      assign ex_diff = p_q[gi] ^ d_q[gi] ^ bw[gi];
      assign ex_bout = (~p_q[gi] & d_q[gi]) | (~(p_q[gi] ^ d_q[gi]) & bw[gi]);
      if (gi < APPROX_COLS) begin : g_apx
        assign diff[gi]  = row_apx ? d_q[gi] : ex_diff;
        assign bw[gi+1]  = row_apx ? p_q[gi] : ex_bout;
      end else begin : g_exact
        assign diff[gi]  = ex_diff;
        assign bw[gi+1]  = ex_bout;
      end
    end
  endgenerate

  assign qbit = p_q[W] | ~bw[W];
  assign rem  = qbit ? diff : p_q[W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      p_q         <= '0;
      d_q         <= '0;
      nsh_q       <= '0;
      qacc_q      <= '0;
      rem_q       <= '0;
      i_q         <= '0;
      apx_q       <= 1'b0;
      dbz_pend_q  <= 1'b0;
      ovf_pend_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      r_q         <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            d_q        <= d;
            apx_q      <= approx_en;
            p_q        <= n[2*W-1:W-1];
            nsh_q      <= {n[W-2:0], 1'b0};
            i_q        <= IW'(W-1);
            in_ready_q <= 1'b0;
            if (d == '0) begin
              // Zero divisor skips the array; the result is staged for DONE.
              qacc_q     <= '1;
              rem_q      <= n[W-1:0];
              dbz_pend_q <= 1'b1;
              ovf_pend_q <= 1'b0;
              state_q    <= DONE;
            end else begin
              qacc_q     <= '0;
              dbz_pend_q <= 1'b0;
              ovf_pend_q <= (n[2*W-1:W] >= d);
              state_q    <= RUN;
            end
          end
        end
        RUN: begin
          qacc_q <= {qacc_q[W-2:0], qbit};
          if (i_q != '0) begin
            p_q   <= {rem, nsh_q[W-1]};
            nsh_q <= {nsh_q[W-2:0], 1'b0};
            i_q   <= i_q - IW'(1);
          end else begin
            rem_q   <= rem;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (!out_valid_q) begin
            q_q         <= qacc_q;
            r_q         <= rem_q;
            dbz_q       <= dbz_pend_q;
            ovf_q       <= ovf_pend_q;
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign r         = r_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;

endmodule
